// File: rtl/wait_state_mem_if.sv
// External-bus connection between the CPU core (master) and the wait-state memory (slave).
// Signal names follow the core's bus naming so the two sides line up one-to-one.
interface wait_state_mem_if;
    logic        cs;
    logic        we;
    logic        oe;
    logic [31:0] address;
    logic [1:0]  data_size;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_into_mcu;
    logic        ram_ready;

    modport master (
        output cs, we, oe, address, data_size, ram_data_in,
        input  ram_data_into_mcu, ram_ready
    );

    modport slave (
        input  cs, we, oe, address, data_size, ram_data_in,
        output ram_data_into_mcu, ram_ready
    );
endinterface

// File: rtl/wait_state_mem.sv
// Word-organised RAM with programmable read/write wait states and a one-cycle ready pulse.
// Byte/halfword/word little-endian lanes; read data is right-justified and zero-extended.
module wait_state_mem #(
    parameter int ADDR_WIDTH    = 10,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    wait_state_mem_if.slave  bus
);

    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_accept;

    logic                  r_we;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [1:0]            r_size;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_cur_we;
    logic [ADDR_WIDTH+1:0] w_cur_addr;
    logic [1:0]            w_cur_size;
    logic [31:0]           w_cur_wdata;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_lane;
    logic [4:0]            w_sh_amt;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata_sh;
    logic [31:0]           w_rd_shift;
    logic [31:0]           w_rd_fmt;
    logic                  w_enter_done;
    logic                  w_commit;
    logic                  w_unused_addr;

    assign w_unused_addr = ^bus.address[31:ADDR_WIDTH+2];

    // NOTE: every variable driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cs && (bus.we || bus.oe)) begin
                    w_accept = 1'b1;
                    if (bus.we) begin
                        w_cnt_nxt   = WR_LOAD;
                        w_state_nxt = (WRITE_LATENCY == 1) ? S_DONE : S_WAIT;
                    end else begin
                        w_cnt_nxt   = RD_LOAD;
                        w_state_nxt = (READ_LATENCY == 1) ? S_DONE : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With a one-cycle latency the access completes on its acceptance edge, so the
    // operation must come straight from the bus rather than from the latched copy.
    always_comb begin
        w_cur_we    = r_we;
        w_cur_addr  = r_addr;
        w_cur_size  = r_size;
        w_cur_wdata = r_wdata;
        if (r_state == S_IDLE) begin
            w_cur_we    = bus.we;
            w_cur_addr  = bus.address[ADDR_WIDTH+1:0];
            w_cur_size  = bus.data_size;
            w_cur_wdata = bus.ram_data_in;
        end
    end

    assign w_idx  = w_cur_addr[ADDR_WIDTH+1:2];
    assign w_lane = w_cur_addr[1:0];

    always_comb begin
        w_sh_amt = 5'd0;
        w_be     = 4'b1111;
        case (w_cur_size)
            2'b00: begin
                w_sh_amt = {w_lane, 3'b000};
                w_be     = 4'b0001 << w_lane;
            end
            2'b01: begin
                w_sh_amt = {w_lane[1], 4'b0000};
                w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_sh_amt = 5'd0;
                w_be     = 4'b1111;
            end
        endcase
    end

    assign w_wdata_sh = w_cur_wdata << w_sh_amt;
    assign w_rd_shift = r_mem[w_idx] >> w_sh_amt;

    always_comb begin
        case (w_cur_size)
            2'b00:   w_rd_fmt = {24'h0, w_rd_shift[7:0]};
            2'b01:   w_rd_fmt = {16'h0, w_rd_shift[15:0]};
            default: w_rd_fmt = w_rd_shift;
        endcase
    end

    assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);
    // A request sitting on the bus while reset is held must not reach the array.
    assign w_commit     = w_enter_done && w_cur_we && rst;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= bus.we;
                r_addr  <= bus.address[ADDR_WIDTH+1:0];
                r_size  <= bus.data_size;
                r_wdata <= bus.ram_data_in;
            end
            if (w_enter_done && !w_cur_we) begin
                r_rdata <= w_rd_fmt;
            end
        end
    end

    // NOTE: the array has no reset; clearing it would forbid a RAM macro and
    // its contents are undefined until written anyway.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign bus.ram_ready         = (r_state == S_DONE);
    assign bus.ram_data_into_mcu = r_rdata;

endmodule

// File: tb/tb_wait_state_mem.sv
// Directed bench for wait_state_mem: vector table on a 2/2-latency instance plus
// reset-abort, latency (3 read / 1 write), back-to-back and idle sequences.
module tb_wait_state_mem;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    wait_state_mem_if m_if ();
    wait_state_mem_if l_if ();

    wait_state_mem #(.ADDR_WIDTH(10), .READ_LATENCY(2), .WRITE_LATENCY(2)) u_main (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    wait_state_mem #(.ADDR_WIDTH(10), .READ_LATENCY(3), .WRITE_LATENCY(1)) u_lat (
        .clk (clk),
        .rst (rst),
        .bus (l_if)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic cs, input logic we, input logic oe,
                         input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        if (sel == 0) begin
            m_if.cs = cs; m_if.we = we; m_if.oe = oe;
            m_if.address = a; m_if.data_size = sz; m_if.ram_data_in = d;
        end else begin
            l_if.cs = cs; l_if.we = we; l_if.oe = oe;
            l_if.address = a; l_if.data_size = sz; l_if.ram_data_in = d;
        end
    endtask

    function automatic logic rdy_of(input int sel);
        return (sel == 0) ? m_if.ram_ready : l_if.ram_ready;
    endfunction

    function automatic logic [31:0] rdata_of(input int sel);
        return (sel == 0) ? m_if.ram_data_into_mcu : l_if.ram_data_into_mcu;
    endfunction

    // One request; cs dropped right after the acceptance edge. Checks latency in
    // cycles after that edge and that ready is a single-cycle pulse.
    task automatic access(input int sel, input string name, input logic wr,
                          input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                          input int exp_lat, output logic [31:0] rd);
        int seen;
        @(negedge clk);
        drive(sel, 1'b1, wr, !wr, a, sz, d);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 1'b0, a, sz, d);
        seen = 0;
        for (int k = 1; k <= 8 && seen == 0; k++) begin
            @(negedge clk);
            if (rdy_of(sel)) seen = k;
        end
        check({name, " latency"}, 32'(seen), 32'(exp_lat));
        rd = rdata_of(sel);
        @(negedge clk);
        check({name, " ready pulse"}, 32'(rdy_of(sel)), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 32'h0000_0020, 2'b10, 32'h1122_3344, 32'h0000_0000};
        vecs[1]  = '{1'b1, 32'h0000_0022, 2'b00, 32'hFFFF_FFAA, 32'h0000_0000};
        vecs[2]  = '{1'b0, 32'h0000_0020, 2'b10, 32'h0,         32'h11AA_3344};
        vecs[3]  = '{1'b0, 32'h0000_0023, 2'b00, 32'h0,         32'h0000_0011};
        vecs[4]  = '{1'b1, 32'h0000_0040, 2'b10, 32'h0000_0000, 32'h0000_0011};
        vecs[5]  = '{1'b1, 32'h0000_0042, 2'b01, 32'h1234_BEEF, 32'h0000_0011};
        vecs[6]  = '{1'b0, 32'h0000_0040, 2'b10, 32'h0,         32'hBEEF_0000};
        vecs[7]  = '{1'b0, 32'h0000_0043, 2'b01, 32'h0,         32'h0000_BEEF};
        vecs[8]  = '{1'b0, 32'h0000_0041, 2'b01, 32'h0,         32'h0000_0000};
        vecs[9]  = '{1'b1, 32'h0000_1004, 2'b10, 32'h5A5A_5A5A, 32'h0000_0000};
        vecs[10] = '{1'b0, 32'h0000_0004, 2'b10, 32'h0,         32'h5A5A_5A5A};
        vecs[11] = '{1'b0, 32'h0000_0021, 2'b00, 32'h0,         32'h0000_0033};
        vecs[12] = '{1'b1, 32'h0000_0020, 2'b01, 32'hFFFF_CAFE, 32'h0000_0033};
        vecs[13] = '{1'b0, 32'h0000_0023, 2'b11, 32'h0,         32'h11AA_CAFE};
        vecs[14] = '{1'b0, 32'h0000_0022, 2'b00, 32'h0,         32'h0000_00AA};
        vecs[15] = '{1'b0, 32'h0000_1020, 2'b10, 32'h0,         32'h11AA_CAFE};

        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("reset ready", 32'(m_if.ram_ready), 32'd0);
        check("reset data", m_if.ram_data_into_mcu, 32'h0);

        // Reset in the middle of a write's wait period aborts it.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 2'b10, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h10, 2'b10, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort ready", 32'(m_if.ram_ready), 32'd0);
        check("abort data", m_if.ram_data_into_mcu, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        access(0, "abort readback", 1'b0, 32'h10, 2'b10, 32'h0, 2, rd);
        n_vec++;
        if (rd === 32'hDEAD_BEEF) begin
            n_miss++;
            $display("FAIL abort readback data: got 0x%08h, aborted write must not land", rd);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("re-reset data", m_if.ram_data_into_mcu, 32'h0);

        for (int i = 0; i < 16; i++) begin
            access(0, $sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].sz,
                   vecs[i].wdata, 2, rd);
            check($sformatf("vec%0d data", i), rd, vecs[i].exp_rd);
        end

        // Latency instance: reads take 3 cycles, writes 1.
        access(1, "lat read0", 1'b0, 32'h0, 2'b10, 32'h0, 3, rd);
        access(1, "lat write", 1'b1, 32'h8, 2'b10, 32'h1234_5678, 1, rd);
        check("lat write keeps data", rd, l_if.ram_data_into_mcu);
        access(1, "lat read8", 1'b0, 32'h8, 2'b10, 32'h0, 3, rd);
        check("lat read8 data", rd, 32'h1234_5678);

        // cs/we/oe held high: write wins, one access every 3 cycles, read data holds.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b1, 32'h80, 2'b10, 32'h0000_0077);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("b2b ready k=%0d", k), 32'(m_if.ram_ready), 32'((k % 3) == 2));
            check($sformatf("b2b data k=%0d", k), m_if.ram_data_into_mcu, 32'h11AA_CAFE);
        end
        drive(0, 1'b0, 1'b0, 1'b1, 32'h80, 2'b10, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("idle ready k=%0d", k), 32'(m_if.ram_ready), 32'd0);
        end
        access(0, "b2b readback", 1'b0, 32'h80, 2'b10, 32'h0, 2, rd);
        check("b2b readback data", rd, 32'h0000_0077);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
